// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM states and the
// byte-lane / word-offset constants used by the responder and its RAM.
package dmem_pkg;

  localparam int BE_W     = 4;
  localparam int ADDR_LSB = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM with per-byte write enables.
// Read data is registered and only updates on an enabled read, so it
// stays stable while the responder holds a response.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  input  logic [BE_W-1:0]       be_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**DEPTH_LOG2];
  logic [31:0] rdata_q;

  // One access per enabled cycle: a store merges the enabled bytes, a load captures the whole word.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < BE_W; b++) begin
          if (be_i[b]) begin
            mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's load/store port: accepts one
// word-addressed request, inserts WAIT_CYCLES wait states, then presents
// a response until the requester takes it.
// Optional feature macro: DMEM_BOUNDS_CHECK_EN -- when defined, any set
// address bit above the storage array faults the request; otherwise the
// upper bits are ignored and addresses alias modulo the depth.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit BoundsCheck = 1'b1;
`else
  localparam bit BoundsCheck = 1'b0;
`endif

  localparam logic [3:0] LastWait = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam bit         NoWait   = (WAIT_CYCLES == 0);

  dmem_state_e           state_q;
  logic [3:0]            waitCnt_q;
  logic                  write_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [31:0]           wdata_q;
  logic [BE_W-1:0]       be_q;
  logic                  err_q;
  logic                  reqReady_q;
  logic                  rspValid_q;

  logic                  reqErr;
  logic [DEPTH_LOG2-1:0] reqIdx;
  logic                  accept;
  logic                  lastWait;
  logic                  ramEn;
  logic                  ramWe;
  logic [DEPTH_LOG2-1:0] ramAddr;
  logic [31:0]           ramWdata;
  logic [BE_W-1:0]       ramBe;
  logic [31:0]           ramRdata;

  // Decode the incoming request and steer the RAM port; the access fires on the edge that enters RESP,
  // which is the accept edge itself when there are no wait states, and is suppressed by reset or a fault.
  always_comb begin
    reqIdx   = req_addr[DEPTH_LOG2+ADDR_LSB-1:ADDR_LSB];
    reqErr   = (req_addr[ADDR_LSB-1:0] != '0) ||
               (BoundsCheck && ((req_addr >> (DEPTH_LOG2 + ADDR_LSB)) != 32'd0));
    accept   = (state_q == IDLE) && req_valid && reqReady_q;
    lastWait = (state_q == WAIT) && (waitCnt_q == LastWait);
    ramEn    = !rst && ((accept && NoWait && !reqErr) || (lastWait && !err_q));
    if (state_q == IDLE) begin
      ramWe    = req_write;
      ramAddr  = reqIdx;
      ramWdata = req_wdata;
      ramBe    = req_be;
    end else begin
      ramWe    = write_q;
      ramAddr  = idx_q;
      ramWdata = wdata_q;
      ramBe    = be_q;
    end
  end

  dmem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk_i   (clk),
    .en_i    (ramEn),
    .we_i    (ramWe),
    .addr_i  (ramAddr),
    .wdata_i (ramWdata),
    .be_i    (ramBe),
    .rdata_o (ramRdata)
  );

  // Responder FSM: latch the request, count wait states, then hold the response until it is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      waitCnt_q  <= 4'd0;
      write_q    <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= 32'd0;
      be_q       <= '0;
      err_q      <= 1'b0;
      reqReady_q <= 1'b1;
      rspValid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            write_q    <= req_write;
            idx_q      <= reqIdx;
            wdata_q    <= req_wdata;
            be_q       <= req_be;
            err_q      <= reqErr;
            waitCnt_q  <= 4'd0;
            reqReady_q <= 1'b0;
            if (NoWait) begin
              state_q    <= RESP;
              rspValid_q <= 1'b1;
            end else begin
              state_q    <= WAIT;
            end
          end
        end
        WAIT: begin
          if (lastWait) begin
            state_q    <= RESP;
            rspValid_q <= 1'b1;
          end else begin
            waitCnt_q  <= waitCnt_q + 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q    <= IDLE;
            rspValid_q <= 1'b0;
            reqReady_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          rspValid_q <= 1'b0;
          reqReady_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = reqReady_q;
  assign rsp_valid = rspValid_q;
  assign rsp_err   = rspValid_q && err_q;
  assign rsp_rdata = (rspValid_q && !write_q && !err_q) ? ramRdata : 32'd0;

endmodule
